key_click_decoder: RTL
======================

Name: key_click_decoder

Overview:
- Sits directly downstream of the key debouncer. Consumes its one-cycle "press confirmed" pulse and the raw key line.
- Classifies each user gesture as exactly one of: single click, double click or long press. Each class has its own one-cycle output pulse.
- Outputs feed UI/control logic (mode select, confirm, reset-hold).

Parameters:
LONG_CYC, 50_000_000, hold time in sclk cycles (1 s at 50 MHz) after the press pulse that qualifies a long press
DBL_CYC, 15_000_000, window in cycles (300 ms) after a confirmed release in which a second press pulse makes a double click
REL_CYC, 500_000, cycles (10 ms) the synchronised key must stay high to count as a confirmed release
CNT_W, 26, width of the gesture timer; must satisfy 2^CNT_W > max(LONG_CYC, DBL_CYC)

Ports:
sclk  input  1  system clock, 50 MHz
nrst  input  1  asynchronous active-low reset
key_n  input  1  raw key line, active low, asynchronous to sclk
key_press  input  1  one-cycle pulse from the debouncer, synchronous to sclk; means the press is confirmed
single_click  output  1  one-cycle pulse: single click classified
double_click  output  1  one-cycle pulse: double click classified
long_press  output  1  one-cycle pulse: long press classified
busy  output  1  high while a gesture is in progress (state != IDLE)

Behaviour:
- Reset nrst, asynchronous, active-low; clock sclk. All flops clear on nrst low, including mid-gesture.
  - State returns to IDLE, timers return to 0, synchroniser flops are set to 1.
  - All outputs are 0 during and after reset until an event occurs.
- key_n passes through a 2-flop synchroniser, giving key_s (2-cycle latency).
- Release counter rel_cnt:
  - Counts while key_s=1 and saturates at REL_CYC-1.
  - Clears whenever key_s=0.
  - rel_ok means rel_cnt == REL_CYC-1 with key_s=1.
- Gesture timer tmr: cleared on every state transition, otherwise increments by 1 each cycle in HELD1 and GAP. No wrap-around is possible given the CNT_W rule.
- FSM, 4 states:
  - IDLE:
    - key_press -> HELD1.
    - key_s alone never leaves IDLE.
  - HELD1 (first press confirmed, key down):
    - tmr == LONG_CYC-1 -> pulse long_press, go to LOCK.
    - else rel_ok -> GAP.
    - key_press is ignored.
    - If long expiry and rel_ok coincide, long_press wins.
  - GAP (released, waiting for a second press):
    - key_press -> pulse double_click, go to LOCK.
    - else tmr == DBL_CYC-1 -> pulse single_click, go to IDLE.
    - If key_press and expiry coincide, double_click wins.
  - LOCK (gesture done, waiting for release):
    - rel_ok -> IDLE.
    - key_press is ignored, so no events fire while the key is still held or bouncing.
- Outputs:
  - Pulses are registered and asserted in the cycle after the deciding condition is sampled.
  - Exactly one cycle wide.
  - At most one of the three pulses is high in any cycle.
  - Exactly one pulse per gesture.
- busy is registered and equals (next state != IDLE), so it rises in the same cycle the FSM leaves IDLE.
- Release bounce shorter than REL_CYC is absorbed by rel_cnt clearing. Low glitches after release cannot create a press because presses come only from key_press.
- A press pulse arriving while key_s is still high is accepted, since key_press is authoritative. Release is then confirmed after REL_CYC cycles.

Decomposition:
- Shared package key_pkg holds:
  - State encoding: IDLE=2'd0, HELD1=2'd1, GAP=2'd2, LOCK=2'd3.
  - Default timing constants (CLK_HZ=50_000_000, LONG/DBL/REL defaults).
  - The debouncer's 20 ms constant, so both blocks share it.
- One sub-module: sync_2ff (generic 2-flop synchroniser with a reset value parameter). It is reused by the debouncer front end.
- Counters and FSM stay in key_click_decoder.

Test Plan:
All scenarios use LONG_CYC=100, DBL_CYC=50, REL_CYC=8, CNT_W=8.
1. Single click: key_n low, key_press at t0, key_n high at t0+20 -> single_click exactly once; no other pulses; busy falls with it.
2. Double click: same as scenario 1, then a second key_press 30 cycles after release is confirmed -> double_click one cycle later, no single_click. Key held low 40 more cycles -> no further pulse. Release -> IDLE after 8+2 cycles.
3. Long press: key_press at t0, key held low 200 cycles -> long_press at t0+101. No pulse on release; busy low about 10 cycles after release.
4. Release bounce: in HELD1, key_n pulses high for 5 cycles, 3 times, then stays low -> remains HELD1; long_press still fires at t0+101.
5. Coincidence: in GAP, key_press lands exactly on the tmr==49 cycle -> double_click only; single_click stays 0.
6. Reset mid-gesture: nrst low for 3 cycles while in GAP (tmr=20) -> all outputs 0, busy 0. A subsequent clean single click is classified normally.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key front end: gesture FSM encoding and default timing constants
// common to the debouncer and the click decoder.
package key_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHeld1 = 2'd1,
    StGap   = 2'd2,
    StLock  = 2'd3
  } key_state_e;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned LONG_CYC_DEF = CLK_HZ;               // 1 s hold
  localparam int unsigned DBL_CYC_DEF  = CLK_HZ / 1000 * 300;  // 300 ms double-click window
  localparam int unsigned REL_CYC_DEF  = CLK_HZ / 1000 * 10;   // 10 ms stable-high release
  localparam int unsigned DEB_CYC      = CLK_HZ / 1000 * 20;   // 20 ms debouncer settle time
  localparam int unsigned CNT_W_DEF    = 26;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level; the reset value is chosen so
// an idle line reads inactive straight out of reset.
module sync_2ff #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d = {sync_q[0], d_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/key_click_decoder.sv
// Classifies each debounced key gesture as single click, double click or long press and emits
// one registered one-cycle pulse per gesture.
module key_click_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC = LONG_CYC_DEF,
  parameter int unsigned DBL_CYC  = DBL_CYC_DEF,
  parameter int unsigned REL_CYC  = REL_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic sclk,
  input  logic nrst,
  input  logic key_n,
  input  logic key_press,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  localparam int unsigned RelW = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;
  localparam logic [RelW-1:0]  RelMax  = RelW'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] LongMax = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DblMax  = CNT_W'(DBL_CYC - 1);

  logic            key_s;
  logic [RelW-1:0] rel_cnt_q, rel_cnt_d;
  logic            rel_ok;
  key_state_e      state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic            single_q, single_d;
  logic            double_q, double_d;
  logic            long_q, long_d;
  logic            busy_q, busy_d;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_key_sync (
    .clk_i  (sclk),
    .rst_ni (nrst),
    .d_i    (key_n),
    .q_o    (key_s)
  );

  // Any low sample restarts the stable-high run, which absorbs release bounce.
  always_comb begin
    rel_cnt_d = rel_cnt_q;
    if (!key_s) begin
      rel_cnt_d = '0;
    end else if (rel_cnt_q != RelMax) begin
      rel_cnt_d = rel_cnt_q + 1'b1;
    end
  end

  assign rel_ok = key_s && (rel_cnt_q == RelMax);

  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_press) state_d = StHeld1;
      end
      StHeld1: begin
        if (tmr_q == LongMax) begin
          long_d  = 1'b1;
          state_d = StLock;
        end else if (rel_ok) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (key_press) begin
          double_d = 1'b1;
          state_d  = StLock;
        end else if (tmr_q == DblMax) begin
          single_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StLock: begin
        if (rel_ok) state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      tmr_d = '0;
    end else if ((state_q == StHeld1) || (state_q == StGap)) begin
      tmr_d = tmr_q + 1'b1;
    end else begin
      tmr_d = tmr_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      rel_cnt_q <= '0;
      state_q   <= StIdle;
      tmr_q     <= '0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rel_cnt_q <= rel_cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
      busy_q    <= busy_d;
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign busy         = busy_q;

endmodule
